// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: a registered scoreboard of in-flight destination
// registers drives operand-forwarding selects, load-use stalls, flushes and freeze control.
module fwd_hazard_ctrl #(
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_id,
  input  logic             redirect,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [3:0]       ff_en,
  output logic [3:0]       ff_rst,
  output logic [1:0]       a_sel,
  output logic [1:0]       b_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } slot_t;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_STALL,
    MODE_FLUSH,
    MODE_WAIT
  } mode_e;

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_RTYPE  = 5'b01100;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  // slot_q[0] is slot 1 (nearest ahead of EX), slot_q[FWD_STAGES-1] the farthest.
  slot_t            slot_q [FWD_STAGES];
  slot_t            slot_d [FWD_STAGES];
  logic [1:0]       a_sel_q, a_sel_d;
  logic [1:0]       b_sel_q, b_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] opc;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       in_vld;
  logic       use_rs1;
  logic       use_rs2;
  slot_t      dec;

  always_comb begin
    opc     = inst_id[6:2];
    rs1     = inst_id[19:15];
    rs2     = inst_id[24:20];
    in_vld  = (inst_id[1:0] == 2'b11);
    use_rs1 = in_vld && (opc != OP_LUI) && (opc != OP_AUIPC) && (opc != OP_JAL);
    use_rs2 = in_vld && ((opc == OP_RTYPE) || (opc == OP_STORE) || (opc == OP_BRANCH));
    dec.vld = in_vld;
    dec.wr  = in_vld && (opc != OP_STORE) && (opc != OP_BRANCH) && (inst_id[11:7] != 5'd0);
    dec.ld  = (inst_id[6:0] == 7'b0000011);
    dec.rd  = inst_id[11:7];
  end

  logic [1:0] a_k, b_k;
  logic       a_hit, b_hit, a_ld, b_ld;
  logic       hazard;

  // Ascending search with a hit flag so the nearest writer takes precedence.
  always_comb begin
    a_k   = '0;
    b_k   = '0;
    a_hit = 1'b0;
    b_hit = 1'b0;
    a_ld  = 1'b0;
    b_ld  = 1'b0;
    for (int unsigned k = 0; k < FWD_STAGES; k++) begin
      if (!a_hit && slot_q[k].vld && slot_q[k].wr && (slot_q[k].rd == rs1)) begin
        a_hit = 1'b1;
        a_k   = 2'(k + 1);
        a_ld  = slot_q[k].ld && ((k + 1) <= LOAD_LAT);
      end
      if (!b_hit && slot_q[k].vld && slot_q[k].wr && (slot_q[k].rd == rs2)) begin
        b_hit = 1'b1;
        b_k   = 2'(k + 1);
        b_ld  = slot_q[k].ld && ((k + 1) <= LOAD_LAT);
      end
    end
    if (!use_rs1 || (rs1 == 5'd0)) begin
      a_k  = '0;
      a_ld = 1'b0;
    end
    if (!use_rs2 || (rs2 == 5'd0)) begin
      b_k  = '0;
      b_ld = 1'b0;
    end
    hazard = a_ld || b_ld;
  end

  mode_e mode;

  always_comb begin
    if (rst)             mode = MODE_RUN;
    else if (!mem_ready) mode = MODE_WAIT;
    else if (redirect)   mode = MODE_FLUSH;
    else if (hazard)     mode = MODE_STALL;
    else                 mode = MODE_RUN;
  end

  always_comb begin
    pc_en  = 1'b1;
    ff_en  = 4'b1111;
    ff_rst = 4'b0000;
    unique case (mode)
      MODE_WAIT: begin
        pc_en = 1'b0;
        ff_en = 4'b0000;
      end
      MODE_FLUSH: ff_rst = 4'b0011;
      MODE_STALL: begin
        pc_en  = 1'b0;
        ff_en  = 4'b1110;
        ff_rst = 4'b0010;
      end
      default: ;
    endcase
  end

  always_comb begin
    slot_d  = slot_q;
    a_sel_d = a_sel_q;
    b_sel_d = b_sel_q;
    cnt_d   = cnt_q;
    if (mode != MODE_WAIT) begin
      for (int unsigned i = 1; i < FWD_STAGES; i++) slot_d[i] = slot_q[i-1];
      if (mode == MODE_RUN) begin
        slot_d[0] = dec;
        a_sel_d   = a_k;
        b_sel_d   = b_k;
      end else begin
        slot_d[0] = '0;
        a_sel_d   = '0;
        b_sel_d   = '0;
      end
      if ((mode == MODE_STALL) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FWD_STAGES; i++) slot_q[i] <= '0;
      a_sel_q <= '0;
      b_sel_q <= '0;
      cnt_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      a_sel_q <= a_sel_d;
      b_sel_q <= b_sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a_sel     = a_sel_q;
  assign b_sel     = b_sel_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: default instance u1 and a LOAD_LAT=2/FWD_STAGES=3
// instance u2 share stimulus; each task checks the instance its scenario targets.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect, mem_ready;
  logic [31:0] inst;

  logic        pc_en1, pc_en2;
  logic [3:0]  ff_en1, ff_rst1, ff_en2, ff_rst2;
  logic [1:0]  a1, b1, a2, b2;
  logic [15:0] cnt1, cnt2;

  fwd_hazard_ctrl u1 (
    .clk(clk), .rst(rst), .inst_id(inst), .redirect(redirect), .mem_ready(mem_ready),
    .pc_en(pc_en1), .ff_en(ff_en1), .ff_rst(ff_rst1), .a_sel(a1), .b_sel(b1), .stall_cnt(cnt1)
  );

  fwd_hazard_ctrl #(.FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .inst_id(inst), .redirect(redirect), .mem_ready(mem_ready),
    .pc_en(pc_en2), .ff_en(ff_en2), .ff_rst(ff_rst2), .a_sel(a2), .b_sel(b2), .stall_cnt(cnt2)
  );

  wire [8:0] ctl1 = {pc_en1, ff_en1, ff_rst1};
  wire [8:0] ctl2 = {pc_en2, ff_en2, ff_rst2};

  localparam logic [8:0] CTL_RUN   = 9'b1_1111_0000;
  localparam logic [8:0] CTL_STALL = 9'b0_1110_0010;
  localparam logic [8:0] CTL_FLUSH = 9'b1_1111_0011;
  localparam logic [8:0] CTL_WAIT  = 9'b0_0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  task automatic clk_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; redirect = 1'b0; mem_ready = 1'b1; inst = NOP;
    clk_edge();
    clk_edge();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; redirect = 1'b0; mem_ready = 1'b1; inst = lw(5'd5, 5'd1);
    clk_edge();
    inst = r_op(7'd0, 3'd0, 5'd6, 5'd5, 5'd5);
    clk_edge();
    total++; if ({a1, b1} !== 4'b0) begin bad++; $display("FAIL reset_sels got=%b exp=0000", {a1, b1}); end
    total++; if (cnt1 !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt1); end
    total++; if ({a2, b2, cnt2} !== 20'd0) begin bad++; $display("FAIL reset_u2 got=%h exp=0", {a2, b2, cnt2}); end
    mem_ready = 1'b0;
    #1;
    total++; if (ctl1 !== CTL_RUN) begin bad++; $display("FAIL reset_ctl_run got=%b exp=%b", ctl1, CTL_RUN); end
    mem_ready = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    inst = r_op(7'd0, 3'd0, 5'd5, 5'd1, 5'd2);
    clk_edge();
    inst = r_op(7'b0100000, 3'd0, 5'd6, 5'd5, 5'd7);
    #1;
    total++; if (ctl1 !== CTL_RUN) begin bad++; $display("FAIL b2b_no_stall got=%b exp=%b", ctl1, CTL_RUN); end
    clk_edge();
    total++; if ({a1, b1} !== 4'b01_00) begin bad++; $display("FAIL b2b_sels got=%b exp=0100", {a1, b1}); end
    // addi x9,x6,5: rs2 field equals 5 (x5 is in slot2) but rs2 is unused
    inst = addi(5'd9, 5'd6, 12'd5);
    clk_edge();
    total++; if ({a1, b1} !== 4'b01_00) begin bad++; $display("FAIL unused_rs2 got=%b exp=0100", {a1, b1}); end
    inst = addi(5'd0, 5'd1, 12'd5);
    clk_edge();
    inst = r_op(7'd0, 3'd0, 5'd1, 5'd0, 5'd0);
    clk_edge();
    total++; if ({a1, b1} !== 4'b00_00) begin bad++; $display("FAIL x0_sels got=%b exp=0000", {a1, b1}); end
  endtask

  task automatic test_distance2;
    do_reset();
    inst = r_op(7'd0, 3'd0, 5'd5, 5'd1, 5'd2);
    clk_edge();
    inst = addi(5'd10, 5'd11, 12'd1);
    clk_edge();
    inst = r_op(7'd0, 3'b110, 5'd8, 5'd9, 5'd5);
    #1;
    total++; if (ctl1 !== CTL_RUN) begin bad++; $display("FAIL dist2_ctl got=%b exp=%b", ctl1, CTL_RUN); end
    clk_edge();
    total++; if ({a1, b1} !== 4'b00_10) begin bad++; $display("FAIL dist2_sels got=%b exp=0010", {a1, b1}); end
  endtask

  task automatic test_load_use;
    do_reset();
    inst = lw(5'd5, 5'd1);
    clk_edge();
    inst = r_op(7'd0, 3'd0, 5'd6, 5'd5, 5'd5);
    #1;
    total++; if (ctl1 !== CTL_STALL) begin bad++; $display("FAIL lu_stall got=%b exp=%b", ctl1, CTL_STALL); end
    clk_edge();
    total++; if (cnt1 !== 16'd1) begin bad++; $display("FAIL lu_cnt_stall got=%0d exp=1", cnt1); end
    total++; if (ctl1 !== CTL_RUN) begin bad++; $display("FAIL lu_resume got=%b exp=%b", ctl1, CTL_RUN); end
    clk_edge();
    total++; if ({a1, b1} !== 4'b10_10) begin bad++; $display("FAIL lu_sels got=%b exp=1010", {a1, b1}); end
    total++; if (cnt1 !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", cnt1); end
  endtask

  task automatic test_load_lat2;
    do_reset();
    inst = lw(5'd5, 5'd1);
    clk_edge();
    inst = r_op(7'd0, 3'd0, 5'd6, 5'd5, 5'd5);
    #1;
    total++; if (ctl2 !== CTL_STALL) begin bad++; $display("FAIL lat2_stall1 got=%b exp=%b", ctl2, CTL_STALL); end
    clk_edge();
    total++; if (ctl2 !== CTL_STALL) begin bad++; $display("FAIL lat2_stall2 got=%b exp=%b", ctl2, CTL_STALL); end
    clk_edge();
    total++; if (ctl2 !== CTL_RUN) begin bad++; $display("FAIL lat2_resume got=%b exp=%b", ctl2, CTL_RUN); end
    total++; if (cnt2 !== 16'd2) begin bad++; $display("FAIL lat2_cnt got=%0d exp=2", cnt2); end
    clk_edge();
    total++; if ({a2, b2} !== 4'b11_11) begin bad++; $display("FAIL lat2_sels got=%b exp=1111", {a2, b2}); end
  endtask

  task automatic test_precedence;
    do_reset();
    inst = r_op(7'd0, 3'd0, 5'd5, 5'd1, 5'd2);
    clk_edge();
    inst = addi(5'd5, 5'd5, 12'd1);
    clk_edge();
    inst = r_op(7'd0, 3'd0, 5'd7, 5'd5, 5'd5);
    clk_edge();
    total++; if ({a1, b1} !== 4'b01_01) begin bad++; $display("FAIL prec_two_writers got=%b exp=0101", {a1, b1}); end
    // An ALU writer in slot1 shadows an older load of the same register.
    inst = lw(5'd5, 5'd1);
    clk_edge();
    inst = addi(5'd5, 5'd3, 12'd1);
    clk_edge();
    inst = r_op(7'd0, 3'd0, 5'd6, 5'd5, 5'd5);
    #1;
    total++; if (ctl1 !== CTL_RUN) begin bad++; $display("FAIL prec_load_shadow got=%b exp=%b", ctl1, CTL_RUN); end
    clk_edge();
    total++; if ({a1, b1} !== 4'b01_01) begin bad++; $display("FAIL prec_shadow_sels got=%b exp=0101", {a1, b1}); end
    inst = sw(5'd2, 5'd1, 12'd5);
    clk_edge();
    inst = r_op(7'd0, 3'd0, 5'd9, 5'd5, 5'd5);
    clk_edge();
    total++; if ({a1, b1} !== 4'b00_00) begin bad++; $display("FAIL store_no_write got=%b exp=0000", {a1, b1}); end
  endtask

  task automatic test_flush_hazard;
    do_reset();
    inst = lw(5'd5, 5'd1);
    clk_edge();
    inst = r_op(7'd0, 3'd0, 5'd6, 5'd5, 5'd5);
    redirect = 1'b1;
    #1;
    total++; if (ctl1 !== CTL_FLUSH) begin bad++; $display("FAIL flush_ctl got=%b exp=%b", ctl1, CTL_FLUSH); end
    clk_edge();
    redirect = 1'b0;
    #1;
    total++; if (cnt1 !== 16'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", cnt1); end
    total++; if (ctl1 !== CTL_RUN) begin bad++; $display("FAIL flush_after got=%b exp=%b", ctl1, CTL_RUN); end
    clk_edge();
    total++; if ({a1, b1} !== 4'b10_10) begin bad++; $display("FAIL flush_shift_sels got=%b exp=1010", {a1, b1}); end
  endtask

  task automatic test_memwait;
    do_reset();
    inst = r_op(7'd0, 3'd0, 5'd5, 5'd1, 5'd2);
    clk_edge();
    inst = r_op(7'b0100000, 3'd0, 5'd6, 5'd5, 5'd7);
    clk_edge();
    inst = lw(5'd5, 5'd1);
    mem_ready = 1'b0;
    #1;
    total++; if (ctl1 !== CTL_WAIT) begin bad++; $display("FAIL wait_ctl got=%b exp=%b", ctl1, CTL_WAIT); end
    clk_edge();
    clk_edge();
    total++; if (a1 !== 2'd1) begin bad++; $display("FAIL wait_sel_hold got=%0d exp=1", a1); end
    mem_ready = 1'b1;
    clk_edge();
    inst = r_op(7'd0, 3'd0, 5'd10, 5'd5, 5'd5);
    #1;
    total++; if (ctl2 !== CTL_STALL) begin bad++; $display("FAIL wait_pre_stall got=%b exp=%b", ctl2, CTL_STALL); end
    clk_edge();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({ctl2, cnt2} !== {CTL_WAIT, 16'd1}) begin bad++; $display("FAIL wait_frozen cyc=%0d got=%b/%0d exp=%b/1", i, ctl2, cnt2, CTL_WAIT); end
      clk_edge();
    end
    mem_ready = 1'b1;
    #1;
    total++; if (ctl2 !== CTL_STALL) begin bad++; $display("FAIL wait_resume_stall got=%b exp=%b", ctl2, CTL_STALL); end
    clk_edge();
    total++; if ({ctl2, cnt2} !== {CTL_RUN, 16'd2}) begin bad++; $display("FAIL wait_done got=%b/%0d exp=%b/2", ctl2, cnt2, CTL_RUN); end
    clk_edge();
    total++; if ({a2, b2} !== 4'b11_11) begin bad++; $display("FAIL wait_sels got=%b exp=1111", {a2, b2}); end
  endtask

  task automatic test_rst_mid_stall;
    do_reset();
    inst = lw(5'd5, 5'd1);
    clk_edge();
    inst = r_op(7'd0, 3'd0, 5'd6, 5'd5, 5'd5);
    #1;
    total++; if (ctl1 !== CTL_STALL) begin bad++; $display("FAIL rst_pre_stall got=%b exp=%b", ctl1, CTL_STALL); end
    rst = 1'b1;
    #1;
    total++; if (ctl1 !== CTL_RUN) begin bad++; $display("FAIL rst_ctl got=%b exp=%b", ctl1, CTL_RUN); end
    clk_edge();
    rst = 1'b0;
    #1;
    total++; if ({a1, b1, cnt1} !== 20'd0) begin bad++; $display("FAIL rst_state got=%h exp=0", {a1, b1, cnt1}); end
    total++; if (ctl1 !== CTL_RUN) begin bad++; $display("FAIL rst_next_run got=%b exp=%b", ctl1, CTL_RUN); end
    clk_edge();
    total++; if ({a1, b1, cnt1} !== 20'd0) begin bad++; $display("FAIL rst_after got=%h exp=0", {a1, b1, cnt1}); end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; mem_ready = 1'b1; inst = NOP;
    #1;
    test_reset();
    test_back_to_back();
    test_distance2();
    test_load_use();
    test_load_lat2();
    test_precedence();
    test_flush_hazard();
    test_memwait();
    test_rst_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
